// File: rtl/ops_pkg.sv
// Shared opcode, flag-index, FIFO-depth and FSM-state constants for the ops block family,
// plus the single-cycle operator evaluator.
package ops_pkg;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_INC = 4'h2;
  localparam logic [3:0] OP_DEC = 4'h3;
  localparam logic [3:0] OP_AND = 4'h4;
  localparam logic [3:0] OP_OR  = 4'h5;
  localparam logic [3:0] OP_XOR = 4'h6;
  localparam logic [3:0] OP_NOT = 4'h7;
  localparam logic [3:0] OP_SHL = 4'h8;
  localparam logic [3:0] OP_SHR = 4'h9;
  localparam logic [3:0] OP_MUL = 4'hA;

  localparam int unsigned FLAG_ZERO  = 0;
  localparam int unsigned FLAG_CARRY = 1;
  localparam int unsigned FLAG_ERR   = 2;

  localparam int unsigned FIFO_DEPTH = 2;
  localparam int unsigned RSP_W      = 11;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_MUL  = 1'b1;

  // Returns {flags[2:0], result[7:0]}; MUL is handled by the sequential datapath, not here.
  function automatic logic [10:0] ops_eval(input logic [3:0] code,
                                           input logic [7:0] a,
                                           input logic [7:0] b);
    logic [8:0] w;
    logic [7:0] res;
    logic [2:0] flags;
    w     = '0;
    res   = '0;
    flags = '0;
    case (code)
      OP_ADD: begin w = {1'b0, a} + {1'b0, b}; res = w[7:0]; flags[FLAG_CARRY] = w[8]; end
      OP_SUB: begin w = {1'b0, a} - {1'b0, b}; res = w[7:0]; flags[FLAG_CARRY] = w[8]; end
      OP_INC: begin w = {1'b0, a} + 9'd1;      res = w[7:0]; flags[FLAG_CARRY] = w[8]; end
      OP_DEC: begin w = {1'b0, a} - 9'd1;      res = w[7:0]; flags[FLAG_CARRY] = w[8]; end
      OP_AND: res = a & b;
      OP_OR:  res = a | b;
      OP_XOR: res = a ^ b;
      OP_NOT: res = ~a;
      OP_SHL: begin res = {a[6:0], 1'b0}; flags[FLAG_CARRY] = a[7]; end
      OP_SHR: begin res = {1'b0, a[7:1]}; flags[FLAG_CARRY] = a[0]; end
      default: flags[FLAG_ERR] = 1'b1;
    endcase
    flags[FLAG_ZERO] = (res == 8'h00);
    return {flags, res};
  endfunction

endpackage

// File: rtl/ops_rsp_fifo.sv
// In-order response buffer; head data reads as zero while empty.
module ops_rsp_fifo #(
  parameter int unsigned WIDTH = 11,
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             din,
  output logic [WIDTH-1:0]             dout,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count < CW'(DEPTH)) || do_pop);
  assign dout    = (count != '0) ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_next(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/ops_responder.sv
// Command/response ALU responder with a 2-entry in-order response buffer.
// Optional 8-cycle shift-add MUL is enabled by defining OPS_RESPONDER_MUL_EN.
module ops_responder
  import ops_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_code,
  input  logic [7:0]  req_a,
  input  logic [7:0]  req_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [7:0]  rsp_result,
  output logic [2:0]  rsp_flags,
  output logic [15:0] op_count
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  logic [CW-1:0]    fcount;
  logic [RSP_W-1:0] push_data;
  logic [RSP_W-1:0] head;
  logic             push;
  logic             req_hs;
  logic             rsp_hs;

  assign req_hs = req_valid && req_ready;
  assign rsp_hs = rsp_valid && rsp_ready;

`ifdef OPS_RESPONDER_MUL_EN
  logic        state;
  logic [15:0] mcand;
  logic [15:0] acc;
  logic [15:0] acc_nx;
  logic [7:0]  mplier;
  logic [2:0]  iter;
  logic        mul_start;
  logic        mul_done;

  assign req_ready = (state == ST_IDLE) && (fcount < CW'(FIFO_DEPTH));
  assign mul_start = req_hs && (req_code == OP_MUL);
  assign mul_done  = (state == ST_MUL) && (iter == 3'd7);
  assign acc_nx    = acc + (mplier[0] ? mcand : '0);
  assign push      = (req_hs && !mul_start) || mul_done;
  // The 8th partial sum is pushed straight from acc_nx so the result lands on edge N+8.
  assign push_data = mul_done ? {1'b0, |acc_nx[15:8], (acc_nx[7:0] == 8'h00), acc_nx[7:0]}
                              : ops_eval(req_code, req_a, req_b);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      mcand  <= '0;
      acc    <= '0;
      mplier <= '0;
      iter   <= '0;
    end else if (state == ST_IDLE) begin
      if (mul_start) begin
        state  <= ST_MUL;
        mcand  <= {8'h00, req_a};
        mplier <= req_b;
        acc    <= '0;
        iter   <= '0;
      end
    end else begin
      acc    <= acc_nx;
      mcand  <= {mcand[14:0], 1'b0};
      mplier <= {1'b0, mplier[7:1]};
      iter   <= iter + 3'd1;
      if (mul_done) state <= ST_IDLE;
    end
  end
`else
  assign req_ready = (fcount < CW'(FIFO_DEPTH));
  assign push      = req_hs;
  assign push_data = ops_eval(req_code, req_a, req_b);
`endif

  ops_rsp_fifo #(.WIDTH(RSP_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (rsp_hs),
    .din   (push_data),
    .dout  (head),
    .count (fcount)
  );

  assign rsp_valid  = (fcount != '0);
  assign rsp_result = head[7:0];
  assign rsp_flags  = head[10:8];

  always_ff @(posedge clk) begin
    if (!rst_n) op_count <= '0;
    else if (rsp_hs) op_count <= op_count + 16'd1;
  end

endmodule

// File: tb/tb_ops_responder.sv
// Directed self-checking bench for ops_responder; MUL steps build only with OPS_RESPONDER_MUL_EN.
module tb_ops_responder;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_code;
  logic [7:0]  req_a;
  logic [7:0]  req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [7:0]  rsp_result;
  logic [2:0]  rsp_flags;
  logic [15:0] op_count;

  int checks;
  int errors;
  int hs;

  ops_responder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_code   (req_code),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_flags  (rsp_flags),
    .op_count   (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input string tag, input logic [3:0] c, input logic [7:0] a,
                      input logic [7:0] b, input logic [7:0] er, input logic [2:0] ef);
    req_code  = c;
    req_a     = a;
    req_b     = b;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    chk({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    chk({tag, "_result"}, 32'(rsp_result), 32'(er));
    chk({tag, "_flags"}, 32'(rsp_flags), 32'(ef));
    tick();
  endtask

  initial begin
    logic [3:0] b2b_code [4];
    logic [7:0] b2b_exp  [4];
    checks    = 0;
    errors    = 0;
    hs        = 0;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    req_code  = 4'h0;
    req_a     = 8'h00;
    req_b     = 8'h00;

    tick();
    tick();
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_result", 32'(rsp_result), 32'h00);
    chk("rst_rsp_flags", 32'(rsp_flags), 32'd0);
    chk("rst_op_count", 32'(op_count), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("rst_req_ready", 32'(req_ready), 32'd1);

    // ADD 0x0A + 0x06
    req_code  = 4'h0;
    req_a     = 8'h0A;
    req_b     = 8'h06;
    req_valid = 1'b1;
    chk("add_req_ready", 32'(req_ready), 32'd1);
    chk("add_pre_valid", 32'(rsp_valid), 32'd0);
    tick();
    req_valid = 1'b0;
    chk("add_valid", 32'(rsp_valid), 32'd1);
    chk("add_result", 32'(rsp_result), 32'h10);
    chk("add_flags", 32'(rsp_flags), 32'b000);
    chk("add_cnt_before", 32'(op_count), 32'd0);
    rsp_ready = 1'b1;
    tick();
    chk("add_cnt_after", 32'(op_count), 32'd1);
    chk("add_empty", 32'(rsp_valid), 32'd0);

    // back-to-back logic ops, rsp_ready held high
    b2b_code[0] = 4'h4; b2b_exp[0] = 8'h08;
    b2b_code[1] = 4'h5; b2b_exp[1] = 8'hEF;
    b2b_code[2] = 4'h6; b2b_exp[2] = 8'hE7;
    b2b_code[3] = 4'h7; b2b_exp[3] = 8'hD4;
    req_a     = 8'h2B;
    req_b     = 8'hCC;
    req_valid = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      req_code = b2b_code[i];
      tick();
      chk("b2b_valid", 32'(rsp_valid), 32'd1);
      chk("b2b_result", 32'(rsp_result), 32'(b2b_exp[i]));
      chk("b2b_flags", 32'(rsp_flags), 32'b000);
    end
    req_valid = 1'b0;
    tick();
    chk("b2b_empty", 32'(rsp_valid), 32'd0);
    chk("b2b_cnt", 32'(op_count), 32'd5);

    // backpressure: two fill the FIFO, third waits
    rsp_ready = 1'b0;
    req_code  = 4'h0;
    req_a     = 8'h01;
    req_b     = 8'h01;
    req_valid = 1'b1;
    tick();
    req_a = 8'h02;
    req_b = 8'h02;
    chk("bp_ready2", 32'(req_ready), 32'd1);
    tick();
    req_a = 8'h03;
    req_b = 8'h03;
    chk("bp_ready3", 32'(req_ready), 32'd0);
    chk("bp_head0", 32'(rsp_result), 32'h02);
    tick();
    chk("bp_hold_ready", 32'(req_ready), 32'd0);
    chk("bp_hold_result", 32'(rsp_result), 32'h02);
    chk("bp_hold_valid", 32'(rsp_valid), 32'd1);
    rsp_ready = 1'b1;
    chk("bp_ready_nocomb", 32'(req_ready), 32'd0);
    tick();
    chk("bp_pop1", 32'(rsp_result), 32'h04);
    chk("bp_slot_free", 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    chk("bp_pop2", 32'(rsp_result), 32'h06);
    tick();
    chk("bp_empty", 32'(rsp_valid), 32'd0);
    chk("bp_cnt", 32'(op_count), 32'd8);

    // arithmetic boundaries and illegal codes
    send("sub", 4'h1, 8'h05, 8'h07, 8'hFE, 3'b010);
    send("dec", 4'h3, 8'h00, 8'h00, 8'hFF, 3'b010);
    send("ill", 4'hF, 8'h12, 8'h34, 8'h00, 3'b101);
    send("shl", 4'h8, 8'h81, 8'h00, 8'h02, 3'b010);
    send("shr", 4'h9, 8'h01, 8'h00, 8'h00, 3'b011);
    send("addc", 4'h0, 8'hFF, 8'h01, 8'h00, 3'b011);
    send("inc", 4'h2, 8'hFF, 8'h00, 8'h00, 3'b011);
    chk("ops_cnt", 32'(op_count), 32'd15);

`ifdef OPS_RESPONDER_MUL_EN
    // MUL 0x10 * 0x11 = 0x0110
    rsp_ready = 1'b0;
    req_code  = 4'hA;
    req_a     = 8'h10;
    req_b     = 8'h11;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    chk("mul_busy_ready", 32'(req_ready), 32'd0);
    for (int unsigned i = 0; i < 7; i++) tick();
    chk("mul_n7_valid", 32'(rsp_valid), 32'd0);
    chk("mul_n7_ready", 32'(req_ready), 32'd0);
    tick();
    chk("mul_valid", 32'(rsp_valid), 32'd1);
    chk("mul_result", 32'(rsp_result), 32'h10);
    chk("mul_flags", 32'(rsp_flags), 32'b010);
    chk("mul_idle_ready", 32'(req_ready), 32'd1);
    rsp_ready = 1'b1;
    tick();
    chk("mul_cnt", 32'(op_count), 32'd16);

    // reset in MUL cycle 4 discards the operation
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mulrst_valid", 32'(rsp_valid), 32'd0);
    chk("mulrst_cnt", 32'(op_count), 32'd0);
    chk("mulrst_ready", 32'(req_ready), 32'd1);
    for (int unsigned i = 0; i < 9; i++) tick();
    chk("mulrst_noresp", 32'(rsp_valid), 32'd0);
`else
    send("ill_mul", 4'hA, 8'h10, 8'h11, 8'h00, 3'b101);
    chk("illmul_cnt", 32'(op_count), 32'd16);
`endif

    // op_count wrap: stream 65535 handshakes from zero, then one more
    rst_n = 1'b0;
    tick();
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    req_code  = 4'h0;
    req_a     = 8'h00;
    req_b     = 8'h00;
    for (int unsigned cyc = 0; cyc < 70000 && hs < 65535; cyc++) begin
      req_valid = 1'b1;
      if (rsp_valid) hs++;
      tick();
    end
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    chk("wrap_hs_budget", 32'(hs), 32'd65535);
    chk("wrap_ffff", 32'(op_count), 32'hFFFF);
    chk("wrap_pending", 32'(rsp_valid), 32'd1);
    chk("wrap_zero_flags", 32'(rsp_flags), 32'b001);
    rsp_ready = 1'b1;
    tick();
    chk("wrap_0000", 32'(op_count), 32'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
